instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 8'h00: PC value loaded on reset.
REQ-002 Parameter ACK_TIMEOUT, default 15: cycles to wait for imem_ack before flagging fetch_err.
REQ-003 The module SHALL have one clock and an asynchronous active-low reset, with the ports listed below.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 imem_req  output  1  instruction-memory read request.
REQ-007 imem_addr  output  8  word address of the request, equal to pc.
REQ-008 imem_ack  input  1  read data valid, single-cycle pulse.
REQ-009 imem_data  input  8  instruction word, sampled when imem_ack=1.
REQ-010 stall  input  1  downstream not ready; holds the issued instruction.
REQ-011 branch  input  1  Branch decode of the currently issued op.
REQ-012 zero  input  1  ALU equality result for the currently issued instruction.
REQ-013 instr  output  8  issued instruction: op=[7:6], rs=[5:4], rt=[3:2], rd/imm=[1:0].
REQ-014 op  output  2  instr[7:6], feeding the control decoder.
REQ-015 instr_valid  output  1  instr/op are valid this cycle.
REQ-016 pc  output  8  address of the issued or pending instruction.
REQ-017 fetch_err  output  1  sticky flag set on an ack timeout.

Function
REQ-018 The FSM SHALL have the states RST, FETCH, WAIT, ISSUE and ERR, encoded in 3 bits.
REQ-019 RST->FETCH: on the first clk edge after rst_n deasserts.
REQ-020 FETCH: imem_req=1 for one cycle, imem_addr=pc, unconditional transition to WAIT.
REQ-021 WAIT: imem_req=1 is held.
REQ-022 WAIT, imem_ack=1: instr<=imem_data and the FSM moves to ISSUE.
REQ-023 WAIT, timeout: after ACK_TIMEOUT cycles without ack, the FSM moves to ERR and sets fetch_err.
REQ-024 imem_ack SHALL be ignored in every state other than WAIT.
REQ-025 ISSUE: instr_valid=1.
REQ-026 ISSUE, stall=1: the FSM remains in ISSUE and instr and pc hold.
REQ-027 ISSUE, stall=0: pc updates per REQ-028 and the FSM moves to FETCH.
REQ-028 PC update: if branch=1 and zero=1, pc<=pc+1+sext(instr[1:0]), otherwise pc<=pc+1.
REQ-029 PC arithmetic SHALL be 8-bit modulo 256, so 8'hFF+1 wraps to 8'h00; imm 2'b11 = -1 and 2'b10 = -2.
REQ-030 branch and zero SHALL be sampled only in the ISSUE cycle with stall=0.
REQ-031 Latency: minimum 3 cycles per instruction (FETCH, WAIT with same-cycle ack, ISSUE).
REQ-032 ERR: terminal state with imem_req=0 and instr_valid=0; exit only via rst_n.
REQ-033 The timeout counter SHALL clear on entry to WAIT and SHALL saturate without wrapping.
REQ-034 op SHALL always equal instr[7:6], including while instr_valid=0.

Reset
REQ-035 While rst_n=0, regardless of clk, outputs SHALL be: pc=RESET_PC, instr=8'h00, op=2'b00, instr_valid=0, imem_req=0, fetch_err=0, state=RST.
REQ-036 Reset asserted mid-WAIT SHALL abandon the request immediately; a late imem_ack after release SHALL be ignored because the FSM is in RST/FETCH, not WAIT.
REQ-037 Reset asserted mid-ISSUE SHALL discard the instruction and apply no PC update.

Verification
REQ-038 Sequential: memory acks in 1 cycle with 8'h1B at addr 0 and 8'h5E at addr 1 -> instr_valid pulses with instr=8'h1B/pc=0, then instr=8'h5E/pc=1, 3 cycles apart.
REQ-039 Branch taken: pc=8'h04, instr=8'hC1, branch=1, zero=1 -> next imem_addr=8'h06; with instr=8'hC3 -> next imem_addr=8'h04.
REQ-040 Branch not taken: pc=8'h04, branch=1, zero=0 -> next imem_addr=8'h05.
REQ-041 Stall: stall=1 for 4 cycles during ISSUE -> instr, pc and instr_valid=1 stable for 5 cycles and no imem_req; the PC update occurs when stall=0.
REQ-042 Wrap and timeout: pc=8'hFF with no branch -> next imem_addr=8'h00; ack withheld for 15 cycles -> fetch_err=1, imem_req=0 and the FSM stays in ERR until rst_n=0.
REQ-043 Async reset: rst_n pulsed low mid-clock during WAIT -> outputs reach reset values before the next edge, and an ack one cycle after release produces no instr_valid.

Source files
------------

// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_if
// Purpose  : Instruction-memory read bus between the fetch unit and memory.
// Revision : 1.0 - initial release
// ============================================================================
interface instr_fetch_if;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Purpose  : Fetch/issue FSM with PC update, stall hold and ack timeout.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter logic [7:0] RESET_PC    = 8'h00,
    parameter int         ACK_TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master imem,
    input  logic          stall,
    input  logic          branch,
    input  logic          zero,
    output logic [7:0]    instr,
    output logic [1:0]    op,
    output logic          instr_valid,
    output logic [7:0]    pc,
    output logic          fetch_err
);

    localparam int c_CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(ACK_TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [2:0] c_ST_RST   = 3'd0;
    localparam logic [2:0] c_ST_FETCH = 3'd1;
    localparam logic [2:0] c_ST_WAIT  = 3'd2;
    localparam logic [2:0] c_ST_ISSUE = 3'd3;
    localparam logic [2:0] c_ST_ERR   = 3'd4;

    logic [2:0]         r_state;
    logic [7:0]         r_pc;
    logic [7:0]         r_instr;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_fetchErr;

    logic [7:0]         w_immExt;
    logic               w_taken;
    logic [7:0]         w_nextPc;

    // Immediate is a signed 2-bit offset relative to pc+1
    assign w_immExt = {{6{r_instr[1]}}, r_instr[1:0]};
    assign w_taken  = branch & zero;
    assign w_nextPc = r_pc + 8'd1 + (w_taken ? w_immExt : 8'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_RST;
            r_pc       <= RESET_PC;
            r_instr    <= 8'h00;
            r_cnt      <= '0;
            r_fetchErr <= 1'b0;
        end else begin
            case (r_state)
                c_ST_RST: begin
                    r_state <= c_ST_FETCH;
                end
                c_ST_FETCH: begin
                    r_state <= c_ST_WAIT;
                    r_cnt   <= '0;
                end
                c_ST_WAIT: begin
                    if (imem.imem_ack) begin
                        r_instr <= imem.imem_data;
                        r_state <= c_ST_ISSUE;
                    end else if (r_cnt >= c_CNT_LAST) begin
                        r_state    <= c_ST_ERR;
                        r_fetchErr <= 1'b1;
                    end else if (r_cnt != c_CNT_MAX) begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                c_ST_ISSUE: begin
                    if (!stall) begin
                        r_pc    <= w_nextPc;
                        r_state <= c_ST_FETCH;
                    end
                end
                c_ST_ERR: begin
                    r_state <= c_ST_ERR;
                end
                default: begin
                    r_state <= c_ST_RST;
                end
            endcase
        end
    end

    assign imem.imem_req  = (r_state == c_ST_FETCH) || (r_state == c_ST_WAIT);
    assign imem.imem_addr = r_pc;
    assign instr          = r_instr;
    assign op             = r_instr[7:6];
    assign instr_valid    = (r_state == c_ST_ISSUE);
    assign pc             = r_pc;
    assign fetch_err      = r_fetchErr;

endmodule
`default_nettype wire
